// File: rtl/issue_partition_replay.sv
// One issue-queue partition: wakeup/select entries with replay residency and a
// drain/off/wake power FSM that gates dispatch into the partition.
module issue_partition_replay #(
  parameter int PART_SIZE  = 8,
  parameter int NUM_PARTS  = 4,
  parameter int PART_ID    = 0,
  parameter int DISPATCH_W = 4,
  parameter int ISSUE_W    = 4,
  parameter int NUM_SRC    = 2,
  parameter int PHY_W      = 7,
  parameter int PIPE_W     = 2,
  parameter int TWO_DEEP   = 0,
  parameter int REPLAY_LAT = 2,
  localparam int IQ_LOG    = $clog2(PART_SIZE * NUM_PARTS)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           flush_i,
  input  logic                           partition_active_i,
  input  logic                           dispatch_ready_i,
  input  logic [DISPATCH_W-1:0]          disp_valid_i,
  input  logic [DISPATCH_W*IQ_LOG-1:0]   disp_id_i,
  input  logic [DISPATCH_W*NUM_SRC-1:0]  disp_src_rdy_i,
  input  logic [DISPATCH_W*PHY_W-1:0]    disp_dest_i,
  input  logic [DISPATCH_W-1:0]          disp_dest_vld_i,
  input  logic [DISPATCH_W*PIPE_W-1:0]   disp_pipe_i,
  input  logic [DISPATCH_W-1:0]          disp_simple_i,
  input  logic [ISSUE_W-1:0]             grant_valid_i,
  input  logic [ISSUE_W*IQ_LOG-1:0]      grant_id_i,
  input  logic                           replay_i,
  input  logic [PART_SIZE*NUM_SRC-1:0]   src_match_i,
  output logic [PART_SIZE-1:0]           req_vect_o,
  output logic [PART_SIZE*PHY_W-1:0]     dest_vect_o,
  output logic [PART_SIZE-1:0]           dest_vld_vect_o,
  output logic [PART_SIZE*PIPE_W-1:0]    pipe_vect_o,
  output logic [PART_SIZE-1:0]           simple_vect_o,
  output logic [PART_SIZE-1:0]           release_o,
  output logic                           part_ready_o,
  output logic [1:0]                     part_state_o,
  output logic                           proto_err_o
);

  localparam int CNT_W = (REPLAY_LAT > 0) ? $clog2(REPLAY_LAT + 1) : 1;

  typedef enum logic [1:0] {
    ST_ON    = 2'b00,
    ST_DRAIN = 2'b01,
    ST_OFF   = 2'b10,
    ST_WAKE  = 2'b11
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [PART_SIZE-1:0]  r_valid;
  logic [PART_SIZE-1:0]  r_issued;
  logic [PART_SIZE-1:0]  r_release;
  logic                  r_err;
  logic [CNT_W-1:0]      r_cnt  [PART_SIZE];
  logic [NUM_SRC-1:0]    r_rdy  [PART_SIZE];
  logic [PHY_W-1:0]      r_dest [PART_SIZE];
  logic [PIPE_W-1:0]     r_pipe [PART_SIZE];
  logic [PART_SIZE-1:0]  r_dest_vld;
  logic [PART_SIZE-1:0]  r_simple;

  logic [DISPATCH_W-1:0] w_lane_hit [PART_SIZE];
  logic [PART_SIZE-1:0]  w_wr_en;
  logic [NUM_SRC-1:0]    w_wr_src  [PART_SIZE];
  logic [PHY_W-1:0]      w_wr_dest [PART_SIZE];
  logic [PIPE_W-1:0]     w_wr_pipe [PART_SIZE];
  logic [PART_SIZE-1:0]  w_wr_dvld;
  logic [PART_SIZE-1:0]  w_wr_simple;
  logic [PART_SIZE-1:0]  w_gnt_hit;
  logic [PART_SIZE-1:0]  w_gnt_ok;
  logic [NUM_SRC-1:0]    w_match   [PART_SIZE];
  logic [PART_SIZE-1:0]  w_req;
  logic                  w_err;

  // Dispatch/grant decode: lanes scanned high to low so the lowest lane wins duplicates.
  always_comb begin
    w_wr_en     = '0;
    w_wr_dvld   = '0;
    w_wr_simple = '0;
    w_gnt_hit   = '0;
    w_err       = 1'b0;
    for (int i = 0; i < PART_SIZE; i++) begin
      w_lane_hit[i] = '0;
      w_wr_src[i]   = '0;
      w_wr_dest[i]  = '0;
      w_wr_pipe[i]  = '0;
      w_match[i]    = src_match_i[i*NUM_SRC +: NUM_SRC];
      for (int k = DISPATCH_W - 1; k >= 0; k--) begin
        w_lane_hit[i][k] = dispatch_ready_i & disp_valid_i[k] &
                           (disp_id_i[k*IQ_LOG +: IQ_LOG] == IQ_LOG'(PART_ID * PART_SIZE + i));
        w_wr_src[i]    = w_lane_hit[i][k] ? disp_src_rdy_i[k*NUM_SRC +: NUM_SRC] : w_wr_src[i];
        w_wr_dest[i]   = w_lane_hit[i][k] ? disp_dest_i[k*PHY_W +: PHY_W] : w_wr_dest[i];
        w_wr_pipe[i]   = w_lane_hit[i][k] ? disp_pipe_i[k*PIPE_W +: PIPE_W] : w_wr_pipe[i];
        w_wr_dvld[i]   = w_lane_hit[i][k] ? disp_dest_vld_i[k] : w_wr_dvld[i];
        w_wr_simple[i] = w_lane_hit[i][k] ? disp_simple_i[k] : w_wr_simple[i];
      end
      for (int g = 0; g < ISSUE_W; g++) begin
        w_gnt_hit[i] = w_gnt_hit[i] | (grant_valid_i[g] &
                       (grant_id_i[g*IQ_LOG +: IQ_LOG] == IQ_LOG'(PART_ID * PART_SIZE + i)));
      end
      w_wr_en[i]  = (|w_lane_hit[i]) & part_ready_o & ~r_valid[i];
      w_gnt_ok[i] = w_gnt_hit[i] & r_valid[i] & ~r_issued[i];
      w_err = w_err | ((|w_lane_hit[i]) & (~part_ready_o | r_valid[i])) |
              (w_gnt_hit[i] & (~r_valid[i] | r_issued[i]));
      w_req[i] = r_valid[i] & ~r_issued[i] &
                 (&(r_rdy[i] | ((TWO_DEEP != 0) ? {NUM_SRC{1'b0}} : w_match[i])));
    end
  end

  // Entry state: dispatch load, wakeup accumulation, grant residency and replay.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid    <= '0;
      r_issued   <= '0;
      r_release  <= '0;
      r_dest_vld <= '0;
      r_simple   <= '0;
      for (int i = 0; i < PART_SIZE; i++) begin
        r_cnt[i]  <= '0;
        r_rdy[i]  <= '0;
        r_dest[i] <= '0;
        r_pipe[i] <= '0;
      end
    end else if (flush_i) begin
      r_valid   <= '0;
      r_issued  <= '0;
      r_release <= '0;
      for (int i = 0; i < PART_SIZE; i++) begin
        r_cnt[i] <= '0;
        r_rdy[i] <= '0;
      end
    end else begin
      for (int i = 0; i < PART_SIZE; i++) begin
        r_release[i] <= 1'b0;
        if (w_wr_en[i]) begin
          r_valid[i]    <= 1'b1;
          r_issued[i]   <= 1'b0;
          r_cnt[i]      <= '0;
          r_rdy[i]      <= w_wr_src[i];
          r_dest[i]     <= w_wr_dest[i];
          r_pipe[i]     <= w_wr_pipe[i];
          r_dest_vld[i] <= w_wr_dvld[i];
          r_simple[i]   <= w_wr_simple[i];
        end else begin
          r_rdy[i] <= (r_rdy[i] | w_match[i]) & {NUM_SRC{r_valid[i]}};
          if (w_gnt_ok[i]) begin
            if (REPLAY_LAT == 0) begin
              r_valid[i]   <= 1'b0;
              r_release[i] <= 1'b1;
            end else begin
              r_issued[i] <= 1'b1;
              r_cnt[i]    <= CNT_W'(REPLAY_LAT);
            end
          end else if (r_issued[i]) begin
            // Replay beats the final countdown step, so a replayed entry is never released.
            if (replay_i && (r_cnt[i] != '0)) begin
              r_issued[i] <= 1'b0;
              r_cnt[i]    <= '0;
            end else if (r_cnt[i] == CNT_W'(1)) begin
              r_valid[i]   <= 1'b0;
              r_issued[i]  <= 1'b0;
              r_cnt[i]     <= '0;
              r_release[i] <= 1'b1;
            end else if (r_cnt[i] != '0) begin
              r_cnt[i] <= r_cnt[i] - CNT_W'(1);
            end
          end
        end
      end
    end
  end

  // Power FSM next state; a returning active request in DRAIN takes priority over going OFF.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ON:    w_state_nxt = partition_active_i ? ST_ON : ST_DRAIN;
      ST_DRAIN: w_state_nxt = partition_active_i ? ST_ON :
                              ((flush_i || (r_valid == '0)) ? ST_OFF : ST_DRAIN);
      ST_OFF:   w_state_nxt = partition_active_i ? ST_WAKE : ST_OFF;
      ST_WAKE:  w_state_nxt = ST_ON;
      default:  w_state_nxt = ST_ON;
    endcase
  end

  // FSM state and sticky protocol error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_ON;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= r_err | w_err;
    end
  end

  for (genvar i = 0; i < PART_SIZE; i++) begin : g_out
    assign dest_vect_o[i*PHY_W +: PHY_W]   = r_dest[i];
    assign pipe_vect_o[i*PIPE_W +: PIPE_W] = r_pipe[i];
  end

  assign req_vect_o      = w_req;
  assign dest_vld_vect_o = r_dest_vld;
  assign simple_vect_o   = r_simple;
  assign release_o       = r_release;
  assign part_ready_o    = (r_state == ST_ON);
  assign part_state_o    = r_state;
  assign proto_err_o     = r_err;

endmodule
